// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - burst read controller: pulls N words from a FIFO into a valid/ready stream
// Keeps at most one read in flight and a 2-entry output buffer whose head drives o_data/o_valid.
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                i_rd_clk,
  input  logic                i_rd_rst_n,
  input  logic                i_start,
  input  logic [ADDRSIZE:0]   i_burst_len,
  input  logic                i_empty,
  input  logic [DATASIZE-1:0] i_rd_data,
  output logic                o_rd_en,
  output logic [DATASIZE-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDRSIZE:0] CNT_ZERO = '0;
  localparam logic [ADDRSIZE:0] CNT_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [ADDRSIZE:0]   issue_cnt;
  logic [ADDRSIZE:0]   out_cnt;
  logic                in_flight;
  logic [DATASIZE-1:0] tail_data;
  logic                tail_valid;
  logic                pop;
  logic [1:0]          occ_after;

  assign pop = o_valid & i_ready;

  // Slots the buffer will hold once the outstanding read lands and this cycle's pop leaves.
  assign occ_after = {1'b0, o_valid} + {1'b0, tail_valid} + {1'b0, in_flight} - {1'b0, pop};

  assign o_rd_en = (state == READ) && !i_empty && (issue_cnt != CNT_ZERO) && (occ_after < 2'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start && (i_burst_len != CNT_ZERO)) state_nxt = READ;
      READ:    if (o_rd_en && (issue_cnt == CNT_ONE)) state_nxt = DRAIN;
      DRAIN:   if (pop && (out_cnt == CNT_ONE)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      issue_cnt  <= CNT_ZERO;
      out_cnt    <= CNT_ZERO;
      in_flight  <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_busy    <= (state_nxt != IDLE);
      o_done    <= (state_nxt == DONE);
      in_flight <= o_rd_en;

      if ((state == IDLE) && (state_nxt == READ)) begin
        issue_cnt <= i_burst_len;
        out_cnt   <= i_burst_len;
      end else begin
        if (o_rd_en) issue_cnt <= issue_cnt - CNT_ONE;
        if (pop && (out_cnt != CNT_ZERO)) out_cnt <= out_cnt - CNT_ONE;
      end

      // Head is o_data/o_valid; the tail only fills when the head is stalled.
      case ({in_flight, pop})
        2'b10: begin
          if (!o_valid) begin
            o_data  <= i_rd_data;
            o_valid <= 1'b1;
          end else begin
            tail_data  <= i_rd_data;
            tail_valid <= 1'b1;
          end
        end
        2'b01: begin
          if (tail_valid) begin
            o_data     <= tail_data;
            tail_valid <= 1'b0;
          end else begin
            o_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (tail_valid) begin
            o_data    <= tail_data;
            tail_data <= i_rd_data;
          end else begin
            o_data <= i_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl with a queue-based FIFO model
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW:0]   i_burst_len = '0;
  logic          i_empty;
  logic [DW-1:0] i_rd_data = '0;
  logic          o_rd_en;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_busy;
  logic          o_done;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            rd_cyc_q[$];
  int            fifo_n = 0;
  int            rd_cnt = 0;
  int            mcyc = 0;
  bit            underflow = 1'b0;

  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            acc_cnt = 0;
  int            acc_first = -1;
  int            acc_last = -1;
  int            cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  assign i_empty = (fifo_n == 0);

  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .i_rd_clk    (clk),
    .i_rd_rst_n  (rst_n),
    .i_start     (i_start),
    .i_burst_len (i_burst_len),
    .i_empty     (i_empty),
    .i_rd_data   (i_rd_data),
    .o_rd_en     (o_rd_en),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  // FIFO model: a read at edge k presents its word on i_rd_data until the next read.
  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    if (o_rd_en) begin
      if (fifo_q.size() == 0) underflow <= 1'b1;
      else i_rd_data <= fifo_q.pop_front();
      rd_cnt <= rd_cnt + 1;
      rd_cyc_q.push_back(mcyc);
    end
    fifo_n <= fifo_q.size();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", {31'd0, o_valid}, 32'd1);
        check("hold_data", {24'd0, o_data}, {24'd0, prev_data});
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", o_data);
        end else begin
          check("stream_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
        end
        acc_cnt++;
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
      end
      if (o_done) done_cnt++;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_burst(input int len);
    i_start     = 1'b1;
    i_burst_len = len[AW:0];
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    i_burst_len = '0;
  endtask

  task automatic clear_stats();
    done_cnt  = 0;
    acc_cnt   = 0;
    acc_first = -1;
    acc_last  = -1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
    cycles(2);
    check({name, "_done_once"}, done_cnt, 32'd1);
    check({name, "_busy_after"}, {31'd0, o_busy}, 32'd0);
    check({name, "_all_words_out"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int base;
    fork
      monitor();
    join_none

    // Reset state
    cycles(3);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
    rst_n = 1'b1;

    // Zero-length start is ignored
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    cycles(2);
    base = rd_cnt;
    start_burst(0);
    cycles(3);
    check("len0_busy", {31'd0, o_busy}, 32'd0);
    check("len0_no_read", rd_cnt - base, 32'd0);
    check("len0_valid", {31'd0, o_valid}, 32'd0);

    // Len=4 at full rate, with an ignored start mid-burst
    clear_stats();
    i_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    base = rd_cnt;
    start_burst(4);
    check("len4_busy", {31'd0, o_busy}, 32'd1);
    cycles(1);
    start_burst(8);
    wait_done("len4", 40);
    check("len4_reads", rd_cnt - base, 32'd4);
    check("len4_rd_consecutive", rd_cyc_q[rd_cyc_q.size()-1] - rd_cyc_q[rd_cyc_q.size()-4], 32'd3);
    check("len4_accepts", acc_cnt, 32'd4);
    check("len4_out_consecutive", acc_last - acc_first, 32'd3);

    // Len=16 (max burst) with i_ready toggling
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      fifo_q.push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'hA0 + 8'(i));
    end
    cycles(2);
    base = rd_cnt;
    i_ready = 1'b1;
    start_burst(16);
    for (int n = 0; n < 200 && done_cnt == 0; n++) begin
      @(posedge clk);
      #1;
      i_ready = ~i_ready;
    end
    i_ready = 1'b1;
    wait_done("len16", 10);
    check("len16_reads", rd_cnt - base, 32'd16);
    check("len16_accepts", acc_cnt, 32'd16);

    // Len=3 with the FIFO running dry
    clear_stats();
    fifo_q.push_back(8'hC1);
    cycles(2);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    base = rd_cnt;
    start_burst(3);
    cycles(3);
    check("dry_first_read", rd_cnt - base, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("dry_rd_en_low", {31'd0, o_rd_en}, 32'd0);
      check("dry_stays_busy", {31'd0, o_busy}, 32'd1);
      cycles(1);
    end
    check("dry_no_done", done_cnt, 32'd0);
    fifo_q.push_back(8'hC2); fifo_q.push_back(8'hC3);
    wait_done("dry", 40);
    check("dry_reads", rd_cnt - base, 32'd3);

    // Reset mid-burst after the 2nd read of len=5
    clear_stats();
    for (int i = 1; i <= 5; i++) fifo_q.push_back(8'h50 + 8'(i));
    cycles(2);
    base = rd_cnt;
    start_burst(5);
    for (int n = 0; n < 20 && rd_cnt < base + 2; n++) cycles(1);
    check("abort_two_reads", rd_cnt - base, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, o_valid}, 32'd0);
    check("abort_data", {24'd0, o_data}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_done", {31'd0, o_done}, 32'd0);
    check("abort_rd_en", {31'd0, o_rd_en}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    exp_q.push_back(8'h53); exp_q.push_back(8'h54);
    start_burst(2);
    check("post_rst_start", {31'd0, o_busy}, 32'd1);
    wait_done("post_rst", 40);
    check("post_rst_fifo_left", fifo_q.size(), 32'd1);

    // Len=2 with downstream stalled
    clear_stats();
    fifo_q.push_back(8'h66);
    cycles(2);
    i_ready = 1'b0;
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    base = rd_cnt;
    start_burst(2);
    cycles(5);
    check("stall_reads", rd_cnt - base, 32'd2);
    check("stall_rd_en", {31'd0, o_rd_en}, 32'd0);
    check("stall_valid", {31'd0, o_valid}, 32'd1);
    check("stall_head", {24'd0, o_data}, 32'h55);
    i_ready = 1'b1;
    wait_done("stall", 20);

    check("fifo_underflow", {31'd0, underflow}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, the FIFO and stream data width.
REQ-002 The block SHALL have parameter ADDRSIZE, default 4; burst length width is ADDRSIZE+1, max burst 2**ADDRSIZE.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- i_rd_clk  in  1  read clock; all state changes on its rising edge.
- i_rd_rst_n  in  1  async active-low reset.
- i_start  in  1  burst request, sampled only in IDLE.
- i_burst_len  in  ADDRSIZE+1  words in the burst, sampled with i_start.
- i_empty  in  1  FIFO empty flag, already in the i_rd_clk domain.
- i_rd_data  in  DATASIZE  FIFO read data, valid the cycle after o_rd_en was high.
- o_rd_en  out  1  FIFO read enable.
- o_data  out  DATASIZE  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  downstream ready.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse at burst completion.

Function
REQ-004 States SHALL be IDLE, READ, DRAIN and DONE.
REQ-005 IDLE -> READ when i_start=1 and i_burst_len is nonzero; i_burst_len loads the issue and output counters. i_start with i_burst_len=0 SHALL be ignored.
REQ-006 READ -> DRAIN on the edge that issues the last read. DRAIN -> DONE when the last word is accepted (o_valid & i_ready). DONE -> IDLE after exactly one cycle.
REQ-007 o_rd_en SHALL be combinational: state=READ & !i_empty & issue counter>0 & (occupancy + in-flight - pop) < 2. pop means o_valid & i_ready in the current cycle.
REQ-008 Read latency: a read issued at edge k SHALL load i_rd_data into the 2-entry output buffer at edge k+1. Only one read SHALL be in flight at a time.
REQ-009 The output buffer SHALL be 2-entry and FIFO-ordered; o_data/o_valid SHALL come from the head entry and be registered.
REQ-010 While i_ready=0 and o_valid=1, o_data SHALL hold stable and no word may be dropped or duplicated.
REQ-011 Load and pop in the same cycle SHALL keep occupancy unchanged and preserve order.
REQ-012 Sustained throughput SHALL be one word per cycle when i_empty=0 and i_ready=1.
REQ-013 i_empty=1 during READ SHALL stall issuing without leaving READ; issuing SHALL resume the cycle i_empty falls.
REQ-014 The issue and output counters SHALL decrement per issued read and per accepted word respectively, with no wrap below 0. A burst of 2**ADDRSIZE SHALL be accepted.
REQ-015 o_done SHALL be high only in DONE; i_start during READ, DRAIN or DONE SHALL be ignored.

Reset
REQ-016 When i_rd_rst_n=0, asynchronously: state=IDLE, counters=0, buffer emptied, o_valid=0, o_data=0, o_busy=0, o_done=0. o_rd_en SHALL be 0 as a consequence of IDLE.
REQ-017 Reset asserted mid-burst SHALL abort the burst. Any in-flight read data SHALL be discarded, and no o_done SHALL follow.
REQ-018 Release of reset SHALL take effect synchronously; the first i_start SHALL be honoured on the first rising edge after deassertion.

Verification
REQ-019 Len=4, FIFO holds 0x11,0x22,0x33,0x44, i_ready=1 -> o_rd_en high 4 consecutive cycles; data 0x11..0x44 on 4 consecutive o_valid cycles; one o_done pulse; o_busy low after.
REQ-020 Len=16, FIFO full, i_ready toggling 1,0 each cycle -> all 16 words in order, none lost or duplicated; o_data stable while i_ready=0; occupancy never exceeds 2.
REQ-021 Len=3, FIFO holds 1 word, 2 more written 10 cycles later -> o_rd_en low while i_empty=1; state stays READ; 3 words out in order; then o_done.
REQ-022 i_start with len=0 -> state stays IDLE, o_busy=0, no o_rd_en. A second i_start during READ -> ignored; the burst count is unchanged.
REQ-023 Reset pulsed in the cycle after the 2nd read of a len=5 burst -> all outputs 0 immediately. Late i_rd_data is ignored. A new len=2 burst after release outputs the next 2 FIFO words.
REQ-024 Len=2, i_ready=0 for 5 cycles -> exactly 2 reads issued, then o_rd_en=0; o_valid holds word 1. Raising i_ready outputs word 1, then word 2, then o_done.
